relu_act_stage: RTL and testbench

//  Activation stage directly downstream of the 3-input weighted-sum neuron block.
//  It takes the IEEE-754 single-precision pre-activation z and applies ReLU or leaky-ReLU.
//  It produces the activation a for the next layer, plus the derivative da/dz for the backprop path.
//  It uses valid/ready handshakes: one compute register feeding a 2-entry output FIFO.

---
 rtl/relu_act_stage.sv | 217 +++++++++++++++++++++
 tb/tb_relu_act_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_act_stage.sv
// ============================================================================
// relu_act_stage
// ----------------------------------------------------------------------------
// Activation stage placed after the weighted-sum neuron. Takes an IEEE-754
// single-precision pre-activation z and produces:
//   - the activation a (ReLU or leaky ReLU)
//   - the derivative da/dz, used by the backprop path
// The data path is one compute register (s1) followed by a 2-entry output
// FIFO. Both ends use valid/ready handshakes.
//
// Parameters
//   LEAKY       1: leaky ReLU with negative slope 2^-LEAK_SHIFT, 0: plain ReLU
//   LEAK_SHIFT  negative-side slope exponent, 1..126
//   CNT_W       width of the saturating negative-input counter
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   z_in     in   [31:0] pre-activation (IEEE-754 single)
//   z_valid  in   z_in valid
//   z_ready  out  stage can accept z_in this cycle
//   a_out    out  [31:0] activation at the FIFO head (0 when empty)
//   d_out    out  [31:0] derivative paired with a_out (0 when empty)
//   a_valid  out  FIFO head valid
//   a_ready  in   consumer takes the head this cycle
//   clr_cnt  in   synchronous clear of neg_cnt (wins over an increment)
//   neg_cnt  out  [CNT_W-1:0] accepted negative nonzero non-NaN inputs,
//                 saturating at all-ones
// ============================================================================
module relu_act_stage #(
   parameter bit          LEAKY      = 1'b1,
   parameter int unsigned LEAK_SHIFT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      z_in,
   input  logic             z_valid,
   output logic             z_ready,
   output logic [31:0]      a_out,
   output logic [31:0]      d_out,
   output logic             a_valid,
   input  logic             a_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] neg_cnt
);

   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [31:0] NEG_INF    = 32'hFF80_0000;
   localparam logic [31:0] ONE        = 32'h3F80_0000;
   localparam logic [7:0]  SHIFT_E    = 8'(LEAK_SHIFT);
   // 2^-LEAK_SHIFT: exponent field 127-LEAK_SHIFT, zero mantissa
   localparam logic [31:0] LEAK_SLOPE = {1'b0, 8'(127 - LEAK_SHIFT), 23'b0};

   // ------------------------------------------------------------------------
   // Field decode and activation/derivative arithmetic on the incoming word
   // ------------------------------------------------------------------------
   logic        z_sign;
   logic [7:0]  z_exp;
   logic [22:0] z_man;
   logic        z_is_nan;
   logic        z_is_neg;
   logic [31:0] act_c;
   logic [31:0] der_c;

   always_comb begin
      z_sign   = z_in[31];
      z_exp    = z_in[30:23];
      z_man    = z_in[22:0];
      z_is_nan = (z_exp == 8'hFF) && (z_man != 23'd0);
      // Negative and nonzero (denormals count as zero) and not NaN; -Inf counts
      z_is_neg = z_sign && (z_exp != 8'd0) && !z_is_nan;

      act_c = 32'd0;
      der_c = 32'd0;
      if (z_is_nan) begin
         // Any NaN, either sign, collapses to the canonical quiet NaN
         act_c = QNAN;
      end else if (z_exp == 8'd0) begin
         // Zero or denormal: flushed, both outputs stay +0
         act_c = 32'd0;
      end else if (!z_sign) begin
         act_c = z_in;
         der_c = ONE;
      end else if (LEAKY) begin
         der_c = LEAK_SLOPE;
         if (z_exp == 8'hFF) begin
            act_c = NEG_INF;
         end else if (z_exp > SHIFT_E) begin
            // Multiplying by a power of two only moves the exponent
            act_c = {1'b1, z_exp - SHIFT_E, z_man};
         end else begin
            // Result would be denormal or smaller: flush to +0
            act_c = 32'd0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Compute register (s1) and 2-entry output FIFO
   // ------------------------------------------------------------------------
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_a_q, s1_a_d;
   logic [31:0] s1_d_q, s1_d_d;

   logic [31:0] mem_a_q [2];
   logic [31:0] mem_a_d [2];
   logic [31:0] mem_d_q [2];
   logic [31:0] mem_d_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  fifo_count_q, fifo_count_d;

   logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;

   logic        accept;
   logic        fifo_pop;
   logic        fifo_push;
   logic        fifo_full;

   // Occupancy of s1 plus FIFO is capped at 2, so an accepted item always
   // has a FIFO slot waiting for it. z_ready deliberately ignores a_ready
   // and z_valid to keep both handshake paths free of combinational loops.
   assign z_ready   = ({1'b0, fifo_count_q} + {2'b00, s1_valid_q}) < 3'd2;
   assign accept    = z_valid && z_ready;
   assign a_valid   = (fifo_count_q != 2'd0);
   assign fifo_pop  = a_valid && a_ready;
   assign fifo_full = (fifo_count_q == 2'd2);
   assign fifo_push = s1_valid_q && (!fifo_full || fifo_pop);

   // Head outputs read as zero while empty, and are stable while held
   assign a_out   = a_valid ? mem_a_q[rd_ptr_q] : 32'd0;
   assign d_out   = a_valid ? mem_d_q[rd_ptr_q] : 32'd0;
   assign neg_cnt = neg_cnt_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_d_d     = s1_d_q;
      if (fifo_push) begin
         s1_valid_d = 1'b0;
      end
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = act_c;
         s1_d_d     = der_c;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         mem_a_d[i] = mem_a_q[i];
         mem_d_d[i] = mem_d_q[i];
      end
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q;

      if (fifo_push) begin
         mem_a_d[wr_ptr_q] = s1_a_q;
         mem_d_d[wr_ptr_q] = s1_d_q;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (fifo_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_count_d = fifo_count_q + 2'd1;
         2'b01:   fifo_count_d = fifo_count_q - 2'd1;
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Saturating negative-input counter
   // ------------------------------------------------------------------------
   always_comb begin
      neg_cnt_d = neg_cnt_q;
      if (clr_cnt) begin
         neg_cnt_d = '0;
      end else if (accept && z_is_neg && (neg_cnt_q != '1)) begin
         neg_cnt_d = neg_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= 32'd0;
         s1_d_q       <= 32'd0;
         for (int i = 0; i < 2; i++) begin
            mem_a_q[i] <= 32'd0;
            mem_d_q[i] <= 32'd0;
         end
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         fifo_count_q <= 2'd0;
         neg_cnt_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_d_q       <= s1_d_d;
         for (int i = 0; i < 2; i++) begin
            mem_a_q[i] <= mem_a_d[i];
            mem_d_q[i] <= mem_d_d[i];
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
         neg_cnt_q    <= neg_cnt_d;
      end
   end

endmodule

// File: tb/tb_relu_act_stage.sv
// ============================================================================
// tb_relu_act_stage
// ----------------------------------------------------------------------------
// Directed and randomised bench for relu_act_stage. Two instances share all
// inputs:
//   u0: leaky ReLU, LEAK_SHIFT=3, 16-bit counter
//   u1: plain ReLU, 3-bit counter (used to reach saturation quickly)
// ============================================================================
module tb_relu_act_stage;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic [31:0] z_in    = 32'd0;
   logic        z_valid = 1'b0;
   logic        a_ready = 1'b0;
   logic        clr_cnt = 1'b0;

   logic        z_ready0, a_valid0;
   logic [31:0] a_out0, d_out0;
   logic [15:0] neg_cnt0;
   logic        z_ready1, a_valid1;
   logic [31:0] a_out1, d_out1;
   logic [2:0]  neg_cnt1;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   relu_act_stage #(.LEAKY(1'b1), .LEAK_SHIFT(3), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .z_in(z_in), .z_valid(z_valid), .z_ready(z_ready0),
      .a_out(a_out0), .d_out(d_out0), .a_valid(a_valid0), .a_ready(a_ready),
      .clr_cnt(clr_cnt), .neg_cnt(neg_cnt0)
   );

   relu_act_stage #(.LEAKY(1'b0), .LEAK_SHIFT(3), .CNT_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .z_in(z_in), .z_valid(z_valid), .z_ready(z_ready1),
      .a_out(a_out1), .d_out(d_out1), .a_valid(a_valid1), .a_ready(a_ready),
      .clr_cnt(clr_cnt), .neg_cnt(neg_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour with LEAK_SHIFT fixed at 3: {activation, derivative}
   function automatic logic [63:0] model(input logic [31:0] z, input bit leaky);
      logic [7:0]  e;
      logic [22:0] m;
      e = z[30:23];
      m = z[22:0];
      if (e == 8'hFF && m != 23'd0) return {32'h7FC00000, 32'h0};
      if (e == 8'd0)                return 64'd0;
      if (!z[31])                   return {z, 32'h3F800000};
      if (!leaky)                   return 64'd0;
      if (e == 8'hFF)               return {32'hFF800000, 32'h3E000000};
      if (e > 8'd3)                 return {1'b1, e - 8'd3, m, 32'h3E000000};
      return {32'h0, 32'h3E000000};
   endfunction

   function automatic bit is_neg(input logic [31:0] z);
      return z[31] && (z[30:23] != 8'd0) && !(z[30:23] == 8'hFF && z[22:0] != 23'd0);
   endfunction

   function automatic logic [31:0] rand_z();
      logic [31:0] r;
      logic [22:0] m;
      logic        s;
      r = $urandom;
      m = r[22:0];
      s = r[31];
      case ($urandom_range(0, 7))
         0:       return {s, 8'hFF, m | 23'd1};                 // NaN
         1:       return {s, 8'hFF, 23'd0};                     // +/-Inf
         2:       return {s, 8'h00, m};                         // zero / denormal
         3:       return {1'b1, 8'($urandom_range(1, 5)), m};   // leak underflow edge
         default: return r;
      endcase
   endfunction

   // One isolated transaction with a_ready=1: accept, then observe at the head
   task automatic single(input string tag, input logic [31:0] z,
                         input logic [31:0] ea0, input logic [31:0] ed0,
                         input logic [31:0] ea1, input logic [31:0] ed1);
      @(negedge clk);
      z_in = z; z_valid = 1'b1;
      chk({tag, " z_ready"}, {31'd0, z_ready0}, 32'd1);
      @(negedge clk);
      z_valid = 1'b0;
      chk({tag, " a_valid_lat0"}, {31'd0, a_valid0}, 32'd0);
      @(negedge clk);
      chk({tag, " a_valid"},  {31'd0, a_valid0}, 32'd1);
      chk({tag, " a_out0"},   a_out0, ea0);
      chk({tag, " d_out0"},   d_out0, ed0);
      chk({tag, " a_valid1"}, {31'd0, a_valid1}, 32'd1);
      chk({tag, " a_out1"},   a_out1, ea1);
      chk({tag, " d_out1"},   d_out1, ed1);
      $display("txn %s z=%h a0=%h d0=%h a1=%h d1=%h", tag, z, a_out0, d_out0, a_out1, d_out1);
   endtask

   typedef struct {
      logic [31:0] a0, d0, a1, d1;
   } exp_t;

   initial begin : stim
      exp_t        q[$];
      exp_t        e;
      logic [63:0] m0, m1;
      logic [15:0] mc0;
      logic [2:0]  mc1;
      int          pushed, popped, cycles;

      // ---------------- reset ----------------
      repeat (2) @(negedge clk);
      chk("rst a_valid", {31'd0, a_valid0}, 32'd0);
      chk("rst a_out",   a_out0, 32'd0);
      chk("rst d_out",   d_out0, 32'd0);
      chk("rst z_ready", {31'd0, z_ready0}, 32'd1);
      chk("rst neg_cnt", {16'd0, neg_cnt0}, 32'd0);
      rst_n   = 1'b1;
      a_ready = 1'b1;

      // ---------------- directed arithmetic ----------------
      single("pos3",    32'h40400000, 32'h40400000, 32'h3F800000, 32'h40400000, 32'h3F800000);
      single("neg4",    32'hC0800000, 32'hBF000000, 32'h3E000000, 32'h0,        32'h0);
      chk("neg4 cnt0", {16'd0, neg_cnt0}, 32'd1);
      chk("neg4 cnt1", {29'd0, neg_cnt1}, 32'd1);
      single("nan",     32'h7FC12345, 32'h7FC00000, 32'h0,        32'h7FC00000, 32'h0);
      single("negzero", 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0);
      single("denorm",  32'h00000001, 32'h0,        32'h0,        32'h0,        32'h0);
      single("under",   32'h81800000, 32'h0,        32'h3E000000, 32'h0,        32'h0);
      single("neginf",  32'hFF800000, 32'hFF800000, 32'h3E000000, 32'h0,        32'h0);
      single("negnan",  32'hFFC00001, 32'h7FC00000, 32'h0,        32'h7FC00000, 32'h0);
      single("posinf",  32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000);
      chk("spec cnt0", {16'd0, neg_cnt0}, 32'd3);
      chk("spec cnt1", {29'd0, neg_cnt1}, 32'd3);

      // ---------------- backpressure ----------------
      @(negedge clk);
      a_ready = 1'b0; z_in = 32'h40000000; z_valid = 1'b1;
      chk("bp rdy0", {31'd0, z_ready0}, 32'd1);
      @(negedge clk);
      z_in = 32'hC1000000;
      chk("bp rdy1", {31'd0, z_ready0}, 32'd1);
      chk("bp av1",  {31'd0, a_valid0}, 32'd0);
      @(negedge clk);
      z_in = 32'hC0800000;
      chk("bp rdy2", {31'd0, z_ready0}, 32'd0);
      chk("bp av2",  {31'd0, a_valid0}, 32'd1);
      chk("bp a2",   a_out0, 32'h40000000);
      @(negedge clk);
      z_in = 32'hC0800000;
      chk("bp rdy3", {31'd0, z_ready0}, 32'd0);
      chk("bp hold", a_out0, 32'h40000000);
      chk("bp holdd", d_out0, 32'h3F800000);
      @(negedge clk);
      chk("bp rdy4", {31'd0, z_ready0}, 32'd0);
      chk("bp hold2", a_out0, 32'h40000000);
      z_valid = 1'b0; a_ready = 1'b1;
      $display("txn bp head=%h", a_out0);
      @(negedge clk);
      chk("bp out1 av", {31'd0, a_valid0}, 32'd1);
      chk("bp out1 a",  a_out0, 32'hBF800000);
      chk("bp out1 d",  d_out0, 32'h3E000000);
      chk("bp out1 a1", a_out1, 32'h0);
      chk("bp rdy5",    {31'd0, z_ready0}, 32'd1);
      $display("txn bp head=%h", a_out0);
      @(negedge clk);
      chk("bp empty", {31'd0, a_valid0}, 32'd0);
      chk("bp cnt0",  {16'd0, neg_cnt0}, 32'd4);

      // ---------------- random valid/ready ----------------
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      mc0 = 16'd0; mc1 = 3'd0;
      pushed = 0; popped = 0; cycles = 0;
      while (popped < 1000 && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         a_ready = ($urandom_range(0, 3) != 0);
         z_valid = (pushed < 1000) && ($urandom_range(0, 1) == 1);
         z_in    = rand_z();
         chk("rnd z_ready", {31'd0, z_ready0}, {31'd0, q.size() < 2});
         if (a_valid0) begin
            if (q.size() == 0) begin
               chk("rnd spurious", {31'd0, a_valid0}, 32'd0);
            end else begin
               e = q[0];
               chk("rnd a0", a_out0, e.a0);
               chk("rnd d0", d_out0, e.d0);
               chk("rnd a1", a_out1, e.a1);
               chk("rnd d1", d_out1, e.d1);
               if (a_ready) begin
                  $display("txn rnd %0d a0=%h d0=%h a1=%h", popped, a_out0, d_out0, a_out1);
                  void'(q.pop_front());
                  popped++;
               end
            end
         end
         if (z_valid && z_ready0) begin
            m0 = model(z_in, 1'b1);
            m1 = model(z_in, 1'b0);
            e.a0 = m0[63:32]; e.d0 = m0[31:0];
            e.a1 = m1[63:32]; e.d1 = m1[31:0];
            q.push_back(e);
            pushed++;
            if (is_neg(z_in)) begin
               if (mc0 != 16'hFFFF) mc0 = mc0 + 16'd1;
               if (mc1 != 3'h7)     mc1 = mc1 + 3'd1;
            end
         end
      end
      chk("rnd done",  popped, 1000);
      chk("rnd cnt0",  {16'd0, neg_cnt0}, {16'd0, mc0});
      chk("rnd cnt1",  {29'd0, neg_cnt1}, {29'd0, mc1});

      // ---------------- counter clear / saturation ----------------
      @(negedge clk);
      z_valid = 1'b0; a_ready = 1'b1;
      repeat (3) @(negedge clk);
      z_in = 32'hC0800000; z_valid = 1'b1; clr_cnt = 1'b1;
      chk("clr rdy", {31'd0, z_ready0}, 32'd1);
      @(negedge clk);
      z_valid = 1'b0; clr_cnt = 1'b0;
      chk("clr cnt0", {16'd0, neg_cnt0}, 32'd0);
      chk("clr cnt1", {29'd0, neg_cnt1}, 32'd0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         single("sat", 32'hC0800000, 32'hBF000000, 32'h3E000000, 32'h0, 32'h0);
      end
      chk("sat cnt1", {29'd0, neg_cnt1}, 32'd7);
      chk("sat cnt0", {16'd0, neg_cnt0}, 32'd8);

      // ---------------- reset mid-stream ----------------
      @(negedge clk);
      a_ready = 1'b0; z_in = 32'h40400000; z_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      z_valid = 1'b0;
      chk("mid av before", {31'd0, a_valid0}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid av",    {31'd0, a_valid0}, 32'd0);
      chk("mid a",     a_out0, 32'd0);
      chk("mid d",     d_out0, 32'd0);
      chk("mid rdy",   {31'd0, z_ready0}, 32'd1);
      chk("mid cnt0",  {16'd0, neg_cnt0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; a_ready = 1'b1;
      @(negedge clk);
      chk("mid empty", {31'd0, a_valid0}, 32'd0);
      single("post", 32'h40400000, 32'h40400000, 32'h3F800000, 32'h40400000, 32'h3F800000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
